// File: rtl/switch_ingress_fifo.sv
// Ingress FIFO ahead of a two-port switch: valid/ready on the upstream side, one-shot issue
// downstream, and saturating per-port issue counters split at ADDR_DIV.
module switch_ingress_fifo #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_DIV = 8'h3F,
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_rdy,
    input  logic                    out_en,
    output logic                    vld,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [DATA_WIDTH-1:0]   data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             cnt_a,
    output logic [15:0]             cnt_b
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

    logic [EW-1:0]         mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  vld_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [15:0]           cnt_a_q, cnt_b_q;

    logic                  push, pop;
    logic [EW-1:0]         rd_entry;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_is_a;

    assign in_rdy   = (level_q != LW'(DEPTH));
    assign push     = in_vld && in_rdy;
    assign pop      = out_en && (level_q != '0);
    assign rd_entry = mem[rd_ptr_q];
    assign rd_addr  = rd_entry[EW-1:DATA_WIDTH];
    assign rd_is_a  = (rd_addr <= ADDR_DIV);

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is deliberately left out of reset; the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            vld_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
        end else begin
            level_q <= level_d;
            vld_q   <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                addr_q   <= rd_addr;
                data_q   <= rd_entry[DATA_WIDTH-1:0];
                if (rd_is_a) begin
                    if (cnt_a_q != 16'hFFFF) cnt_a_q <= cnt_a_q + 16'd1;
                end else begin
                    if (cnt_b_q != 16'hFFFF) cnt_b_q <= cnt_b_q + 16'd1;
                end
            end
        end
    end

    assign vld   = vld_q;
    assign addr  = addr_q;
    assign data  = data_q;
    assign level = level_q;
    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;

endmodule
